// File: rtl/gfx_pkg.sv
// Shared graphics constants and small types for the render_* shape generators.
package gfx_pkg;

  localparam int CORDW     = 16;
  localparam int CIDXW     = 4;
  localparam int FB_WIDTH  = 320;
  localparam int FB_HEIGHT = 180;

  typedef enum logic {
    DIR_POS = 1'b0,
    DIR_NEG = 1'b1
  } dir_t;

endpackage

// File: rtl/draw_rect_fill.sv
// Filled-rectangle scanner: emits every pixel of [x0..x1] x [y0..y1] in raster
// order, one per cycle while oe is high, then pulses done.
module draw_rect_fill #(
  parameter int CORDW = gfx_pkg::CORDW
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    oe,
  input  logic signed [CORDW-1:0] x0,
  input  logic signed [CORDW-1:0] y0,
  input  logic signed [CORDW-1:0] x1,
  input  logic signed [CORDW-1:0] y1,
  output logic signed [CORDW-1:0] x,
  output logic signed [CORDW-1:0] y,
  output logic                    drawing,
  output logic                    done
);

  typedef enum logic [1:0] {
    RF_IDLE,
    RF_DRAW,
    RF_DONE
  } rf_state_t;

  localparam logic signed [CORDW-1:0] ONE_C = CORDW'(1);

  rf_state_t               state, state_next;
  logic signed [CORDW-1:0] x_left, x_right, y_bottom;
  logic                    last_px;

  assign last_px = (x == x_right) && (y == y_bottom);

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    drawing    = 1'b0;
    done       = 1'b0;
    unique case (state)
      RF_IDLE: if (start) state_next = RF_DRAW;
      RF_DRAW: begin
        drawing = oe;
        if (oe && last_px) state_next = RF_DONE;
      end
      RF_DONE: begin
        done       = 1'b1;
        state_next = RF_IDLE;
      end
      default: state_next = RF_IDLE;
    endcase
  end

  // NOTE: registers use <= so each one updates from pre-edge values, independent of order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RF_IDLE;
      x        <= '0;
      y        <= '0;
      x_left   <= '0;
      x_right  <= '0;
      y_bottom <= '0;
    end else begin
      state <= state_next;
      if (state == RF_IDLE && start) begin
        x        <= x0;
        y        <= y0;
        x_left   <= x0;
        x_right  <= x1;
        y_bottom <= y1;
      end else if (state == RF_DRAW && oe && !last_px) begin
        // Coordinates hold on the final pixel so downstream sees a stable value.
        if (x == x_right) begin
          x <= x_left;
          y <= y + ONE_C;
        end else begin
          x <= x + ONE_C;
        end
      end
    end
  end

endmodule

// File: rtl/render_bounce_rect.sv
// Bouncing filled square: each start moves the square one step (reflecting off
// the drawing-area walls, recolouring on every hit) and then rasterises it.
module render_bounce_rect #(
  parameter int CORDW     = gfx_pkg::CORDW,
  parameter int CIDXW     = gfx_pkg::CIDXW,
  parameter int SCALE     = 1,
  parameter int FB_WIDTH  = gfx_pkg::FB_WIDTH,
  parameter int FB_HEIGHT = gfx_pkg::FB_HEIGHT,
  parameter int SIZE      = 40,
  parameter int SPEED     = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    oe,
  input  logic                    start,
  output logic signed [CORDW-1:0] x,
  output logic signed [CORDW-1:0] y,
  output logic        [CIDXW-1:0] cidx,
  output logic                    drawing,
  output logic                    done
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MOVE,
    ST_INIT,
    ST_DRAW,
    ST_DONE
  } state_t;

  localparam logic signed [CORDW-1:0] W_C     = CORDW'(FB_WIDTH * SCALE);
  localparam logic signed [CORDW-1:0] H_C     = CORDW'(FB_HEIGHT * SCALE);
  localparam logic signed [CORDW-1:0] SIZE_C  = CORDW'(SIZE);
  localparam logic signed [CORDW-1:0] SPEED_C = CORDW'(SPEED);
  localparam logic signed [CORDW-1:0] ONE_C   = CORDW'(1);
  localparam logic        [CIDXW-1:0] CIDX_1  = CIDXW'(1);

  state_t                  state, state_next;
  logic signed [CORDW-1:0] qx, qy, qx_nx, qy_nx, rx1, ry1;
  gfx_pkg::dir_t           dirx, diry, dirx_nx, diry_nx;
  logic                    hit_x, hit_y, rect_start, last_px;

  assign rx1        = qx + SIZE_C - ONE_C;
  assign ry1        = qy + SIZE_C - ONE_C;
  assign rect_start = (state == ST_INIT);
  assign last_px    = drawing && (x == rx1) && (y == ry1);

  // One step per axis; a wall hit reflects the step instead of crossing the edge.
  always_comb begin
    qx_nx   = qx;
    qy_nx   = qy;
    dirx_nx = dirx;
    diry_nx = diry;
    hit_x   = 1'b0;
    hit_y   = 1'b0;
    if (dirx == gfx_pkg::DIR_POS) begin
      if (qx + SIZE_C + SPEED_C > W_C) begin
        qx_nx   = qx - SPEED_C;
        dirx_nx = gfx_pkg::DIR_NEG;
        hit_x   = 1'b1;
      end else begin
        qx_nx = qx + SPEED_C;
      end
    end else if (qx < SPEED_C) begin
      qx_nx   = qx + SPEED_C;
      dirx_nx = gfx_pkg::DIR_POS;
      hit_x   = 1'b1;
    end else begin
      qx_nx = qx - SPEED_C;
    end
    if (diry == gfx_pkg::DIR_POS) begin
      if (qy + SIZE_C + SPEED_C > H_C) begin
        qy_nx   = qy - SPEED_C;
        diry_nx = gfx_pkg::DIR_NEG;
        hit_y   = 1'b1;
      end else begin
        qy_nx = qy + SPEED_C;
      end
    end else if (qy < SPEED_C) begin
      qy_nx   = qy + SPEED_C;
      diry_nx = gfx_pkg::DIR_POS;
      hit_y   = 1'b1;
    end else begin
      qy_nx = qy - SPEED_C;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (start) state_next = ST_MOVE;
      ST_MOVE: state_next = ST_INIT;
      ST_INIT: state_next = ST_DRAW;
      ST_DRAW: if (last_px) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      qx    <= '0;
      qy    <= '0;
      dirx  <= gfx_pkg::DIR_POS;
      diry  <= gfx_pkg::DIR_POS;
      cidx  <= CIDX_1;
    end else begin
      state <= state_next;
      if (state == ST_MOVE) begin
        qx   <= qx_nx;
        qy   <= qy_nx;
        dirx <= dirx_nx;
        diry <= diry_nx;
        // Index 0 is the clear colour, so the sequence wraps from all-ones back to 1.
        if (hit_x || hit_y) cidx <= (cidx == '1) ? CIDX_1 : cidx + CIDX_1;
      end
    end
  end

  draw_rect_fill #(
    .CORDW(CORDW)
  ) u_rect (
    .clk    (clk),
    .rst    (rst),
    .start  (rect_start),
    .oe     (oe),
    .x0     (qx),
    .y0     (qy),
    .x1     (rx1),
    .y1     (ry1),
    .x      (x),
    .y      (y),
    .drawing(drawing),
    .done   (done)
  );

endmodule

// File: tb/tb_render_bounce_rect.sv
// Scoreboard bench: a frame-level model queues expected pixels; monitors pop and compare.
module tb_render_bounce_rect;

  localparam int AW = 320, AH = 180, AS = 40, AV = 1;
  localparam int BW = 23,  BH = 14,  BS = 4,  BV = 2;
  localparam int CMAX = 15;

  typedef struct {int x; int y; int c;} pix_t;
  typedef struct {int qx; int qy; int dx; int dy; int c;} model_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic               a_rst, a_oe, a_start, a_drawing, a_done;
  logic signed [15:0] a_x, a_y;
  logic        [3:0]  a_cidx;
  logic               b_rst, b_oe, b_start, b_drawing, b_done;
  logic signed [15:0] b_x, b_y;
  logic        [3:0]  b_cidx;

  render_bounce_rect dut_a (
    .clk(clk), .rst(a_rst), .oe(a_oe), .start(a_start),
    .x(a_x), .y(a_y), .cidx(a_cidx), .drawing(a_drawing), .done(a_done)
  );

  render_bounce_rect #(
    .FB_WIDTH(BW), .FB_HEIGHT(BH), .SIZE(BS), .SPEED(BV)
  ) dut_b (
    .clk(clk), .rst(b_rst), .oe(b_oe), .start(b_start),
    .x(b_x), .y(b_y), .cidx(b_cidx), .drawing(b_drawing), .done(b_done)
  );

  pix_t   qa[$], qb[$];
  model_t ma, mb;
  int     vectors = 0, miscompares = 0;
  int     a_pix = 0, a_dones = 0, a_done_cyc = 0, b_dones = 0;
  bit     a_active = 0, b_active = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] pk(input logic [15:0] px, input logic [15:0] py,
                                     input logic [7:0] pc);
    return {24'd0, px, py, pc};
  endfunction

  function automatic model_t model_reset();
    model_t m;
    m = '{qx: 0, qy: 0, dx: 1, dy: 1, c: 1};
    return m;
  endfunction

  // Reflect off a wall when the next step would leave [0, lim).
  task automatic axis(inout int q, inout int d, input int lim, input int size,
                      input int speed, output bit hit);
    hit = 0;
    if (d > 0 && q + size + speed > lim)  begin d = -1; hit = 1; end
    else if (d < 0 && q < speed)          begin d = 1;  hit = 1; end
    q = q + d * speed;
  endtask

  task automatic model_frame(inout model_t m, input int w, input int h, input int size,
                             input int speed, input bit to_b);
    int q, d;
    bit hx, hy;
    pix_t p;
    q = m.qx; d = m.dx; axis(q, d, w, size, speed, hx); m.qx = q; m.dx = d;
    q = m.qy; d = m.dy; axis(q, d, h, size, speed, hy); m.qy = q; m.dy = d;
    if (hx || hy) m.c = (m.c == CMAX) ? 1 : m.c + 1;
    for (int yy = m.qy; yy < m.qy + size; yy++)
      for (int xx = m.qx; xx < m.qx + size; xx++) begin
        p = '{x: xx, y: yy, c: m.c};
        if (to_b) qb.push_back(p); else qa.push_back(p);
      end
  endtask

  // Monitor A: pops one expected pixel per drawing cycle; stalled outputs must hold the next pixel.
  always @(negedge clk) begin
    pix_t e;
    if (!a_rst) begin
      if (a_drawing) begin
        a_pix++;
        a_active = 1;
        check("a_pixel_expected", qa.size() > 0, 1);
        if (qa.size() > 0) begin
          e = qa.pop_front();
          check("a_pixel", pk(a_x, a_y, {4'd0, a_cidx}), pk(16'(e.x), 16'(e.y), 8'(e.c)));
        end
      end else if (a_active && qa.size() > 0) begin
        check("a_hold_xy", pk(a_x, a_y, 8'd0), pk(16'(qa[0].x), 16'(qa[0].y), 8'd0));
      end
      if (a_done) begin
        a_dones++;
        a_done_cyc = cyc;
        a_active   = 0;
        check("a_done_drained", qa.size(), 0);
      end
    end
  end

  always @(negedge clk) begin
    pix_t e;
    if (!b_rst) begin
      if (b_drawing) begin
        b_active = 1;
        check("b_in_bounds", (b_x >= 0 && b_x < BW && b_y >= 0 && b_y < BH), 1);
        check("b_pixel_expected", qb.size() > 0, 1);
        if (qb.size() > 0) begin
          e = qb.pop_front();
          check("b_pixel", pk(b_x, b_y, {4'd0, b_cidx}), pk(16'(e.x), 16'(e.y), 8'(e.c)));
        end
      end else if (b_active && qb.size() > 0) begin
        check("b_hold_xy", pk(b_x, b_y, 8'd0), pk(16'(qb[0].x), 16'(qb[0].y), 8'd0));
      end
      if (b_done) begin
        b_dones++;
        b_active = 0;
        check("b_done_drained", qb.size(), 0);
      end
    end
  end

  task automatic frame_a(input bit rand_oe, input bit start_mid, input int abort_at,
                         input bit chk_latency);
    int t0, d0, n;
    model_frame(ma, AW, AH, AS, AV, 0);
    a_pix = 0;
    d0    = a_dones;
    @(posedge clk); #1;
    a_start = 1;
    a_oe    = rand_oe ? 1'($urandom_range(0, 1)) : 1'b1;
    t0      = cyc;
    @(posedge clk); #1;
    a_start = 0;
    n = 0;
    while (a_dones == d0 && n < 8000) begin
      a_oe    = rand_oe ? 1'($urandom_range(0, 1)) : 1'b1;
      a_start = start_mid && (a_pix == 700);
      if (abort_at > 0 && a_pix >= abort_at) begin
        a_rst = 1; a_start = 0;
        qa.delete();
        a_active = 0;
        @(posedge clk); #1;
        a_rst = 0;
        @(negedge clk);
        check("a_abort_state", pk(a_x, a_y, {a_drawing, a_done, 2'b00, a_cidx}),
              pk(16'd0, 16'd0, 8'd1));
        ma = model_reset();
        d0 = a_dones;
        repeat (1200) @(posedge clk);
        #1;
        check("a_no_done_after_rst", a_dones, d0);
        return;
      end
      @(posedge clk); #1;
      n++;
    end
    a_start = 0;
    repeat (3) @(posedge clk);
    #1;
    check("a_done_once", a_dones - d0, 1);
    check("a_pixel_count", a_pix, AS * AS);
    if (chk_latency) check("a_done_latency", a_done_cyc - t0, 3 + AS * AS);
  endtask

  task automatic frame_b();
    int d0, n;
    model_frame(mb, BW, BH, BS, BV, 1);
    d0 = b_dones;
    @(posedge clk); #1;
    b_start = 1;
    @(posedge clk); #1;
    b_start = 0;
    n = 0;
    while (b_dones == d0 && n < 400) begin
      b_oe = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
      n++;
    end
    check("b_done_seen", b_dones - d0, 1);
  endtask

  initial begin
    #3_000_000;
    $display("watchdog expired at cycle %0d", cyc);
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    a_rst = 1; a_oe = 1; a_start = 0;
    b_rst = 1; b_oe = 1; b_start = 0;
    ma = model_reset();
    mb = model_reset();
    repeat (3) @(posedge clk);
    #1;
    a_rst = 0; b_rst = 0;
    @(negedge clk);
    check("a_reset_xy", pk(a_x, a_y, 8'd0), 64'd0);
    check("a_reset_flags", {a_drawing, a_done}, 2'b00);
    check("a_reset_cidx", a_cidx, 1);
    check("b_reset_xy", pk(b_x, b_y, 8'd0), 64'd0);
    check("b_reset_flags", {b_drawing, b_done}, 2'b00);
    check("b_reset_cidx", b_cidx, 1);

    frame_a(0, 0, 0, 1);    // first frame from reset: square at (1,1), colour 1
    frame_a(1, 0, 0, 0);    // random output-enable stalls
    frame_a(0, 1, 0, 1);    // start pulse mid-draw must be ignored
    frame_a(0, 0, 500, 0);  // reset mid-frame
    frame_a(0, 0, 0, 1);    // redraw from (1,1) after reset

    for (int f = 0; f < 1200; f++) frame_b();  // small area: many bounces, corners, colour wraps

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
